// File: rtl/instr_prefetch_queue_if.sv
// Memory-fetch and CPU-delivery handshake bundle for instr_prefetch_queue.
// master = the prefetch queue, slave = instruction memory plus CPU fetch stage.
interface instr_prefetch_queue_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic [1:0]  mem_rsp_exc;
  logic        instr_valid;
  logic [63:0] instr_data;
  logic [63:0] instr_addr;
  logic [1:0]  instr_exc;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_exc,
    output instr_valid, instr_data, instr_addr, instr_exc,
    input  instr_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_exc,
    input  instr_valid, instr_data, instr_addr, instr_exc,
    output instr_ready
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction fetcher with an in-order prefetch FIFO. Start/redirect flush the
// queue; responses still in flight at a flush are counted in dropCnt and discarded.
module instr_prefetch_queue #(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2,
  parameter int INSTR_B   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [63:0]            start_addr,
  input  logic                   redirect,
  input  logic [63:0]            redirect_addr,
  instr_prefetch_queue_if.master bus,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} stateT;

  stateT         state, stateNext;
  logic [63:0]   fetchPc;
  logic [OW-1:0] outstanding, dropCnt, outNext;
  logic [TW-1:0] tagWr, tagRd;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic [63:0]   tagMem  [MAX_OUTST];
  logic [63:0]   dataMem [DEPTH];
  logic [63:0]   addrMem [DEPTH];
  logic [1:0]    excMem  [DEPTH];

  logic          flush, issue, rspAccept, fifoPush, fifoPop, headValid;
  logic [63:0]   flushAddr;

  function automatic logic [TW-1:0] tagInc(input logic [TW-1:0] p);
    return (int'(p) == MAX_OUTST - 1) ? '0 : p + TW'(1);
  endfunction

  // Issue depends on registers only; a redirect in FETCH may still see its own-cycle request,
  // which is then counted as stale.
  always_comb begin
    headValid = (count != '0);
    flush     = start || (redirect && state != IDLE);
    flushAddr = start ? start_addr : redirect_addr;
    issue     = (state == FETCH) && (int'(outstanding) < MAX_OUTST)
                && (int'(count) + int'(outstanding) < DEPTH);
    rspAccept = bus.mem_rsp_valid && (outstanding != '0);
    fifoPush  = rspAccept && (dropCnt == '0) && !flush;
    fifoPop   = headValid && bus.instr_ready && !flush;
    outNext   = outstanding + OW'(issue) - OW'(rspAccept);
  end

  // NOTE: stateNext gets its default first so every path assigns it and no latch is inferred.
  always_comb begin
    stateNext = state;
    if (flush) begin
      stateNext = FETCH;
    end else if (state == FETCH && fifoPush && bus.mem_rsp_exc != 2'd0) begin
      stateNext = HALT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc     <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
      tagWr       <= '0;
      tagRd       <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
    end else begin
      outstanding <= outNext;
      if (issue)     tagWr <= tagInc(tagWr);
      if (rspAccept) tagRd <= tagInc(tagRd);
      if (flush) begin
        // Everything still in flight after this cycle belongs to the old stream.
        fetchPc <= flushAddr;
        dropCnt <= outNext;
        wrPtr   <= '0;
        rdPtr   <= '0;
        count   <= '0;
      end else begin
        if (issue)                        fetchPc <= fetchPc + 64'(INSTR_B);
        if (rspAccept && dropCnt != '0)   dropCnt <= dropCnt - OW'(1);
        if (fifoPush)                     wrPtr   <= wrPtr + AW'(1);
        if (fifoPop)                      rdPtr   <= rdPtr + AW'(1);
        count <= count + (AW+1)'(fifoPush) - (AW+1)'(fifoPop);
      end
    end
  end

  // NOTE: storage arrays are not reset; every read is masked by headValid so stale contents never escape.
  always_ff @(posedge clk) begin
    if (issue) tagMem[tagWr] <= fetchPc;
    if (fifoPush) begin
      dataMem[wrPtr] <= bus.mem_rsp_data;
      addrMem[wrPtr] <= tagMem[tagRd];
      excMem[wrPtr]  <= bus.mem_rsp_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(fifoPush && !fifoPop && int'(count) == DEPTH))
        else $error("prefetch queue overflow");
    end
  end

  assign bus.mem_req     = issue;
  assign bus.mem_addr    = fetchPc;
  assign bus.instr_valid = headValid;
  assign bus.instr_data  = headValid ? dataMem[rdPtr] : '0;
  assign bus.instr_addr  = headValid ? addrMem[rdPtr] : '0;
  assign bus.instr_exc   = headValid ? excMem[rdPtr]  : '0;
  assign busy            = (state != IDLE) || (outstanding != '0);
endmodule
